// File: rtl/udm_arb_pkg.sv
// Shared types and constants for the udm bus arbiter.
package udm_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic UDM_ARB_M0 = 1'b0;
  localparam logic UDM_ARB_M1 = 1'b1;

  // Read data returned to the owner when a transaction is force-completed.
  localparam logic [31:0] UDM_ARB_TIMEOUT_RDATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/udm_arb_rr_pick.sv
// Two-way round-robin chooser: a lone requester wins, on a tie the master
// that did not win last time is granted.
module udm_arb_rr_pick
  import udm_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_grant_valid,
  output logic       o_grant_idx
);

  // Combinational grant selection.
  always_comb begin
    o_grant_valid = |i_req;
    o_grant_idx   = UDM_ARB_M0;
    case (i_req)
      2'b01:   o_grant_idx = UDM_ARB_M0;
      2'b10:   o_grant_idx = UDM_ARB_M1;
      2'b11:   o_grant_idx = ~i_last;
      default: o_grant_idx = UDM_ARB_M0;
    endcase
  end

endmodule

// File: rtl/udm_bus_arbiter.sv
// Shares one slave bus between the udm debug master (M0) and the CPU master
// (M1) with transaction-granular round-robin arbitration.
// Optional forced-completion watchdog enabled by defining UDM_ARB_TIMEOUT_EN.
module udm_bus_arbiter
  import udm_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = DATA_W'(UDM_ARB_TIMEOUT_RDATA_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_bi,
  input  logic [DATA_W-1:0] m0_wdata_bi,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_bo,
  input  logic              m1_enb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_bi,
  input  logic [DATA_W-1:0] m1_wdata_bi,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_bo,
  output logic              s_enb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_bo,
  output logic [DATA_W-1:0] s_wdata_bo,
  input  logic              s_ack_i,
  input  logic [DATA_W-1:0] s_rdata_bi,
  output logic              owner_o,
  output logic              busy_o,
  output logic              timeout_o
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_owner;
  logic              r_last_grant;
  logic              w_grant_valid;
  logic              w_grant_idx;
  logic              w_busy;
  logic              w_force;
  logic              w_complete;
  logic [DATA_W-1:0] w_ack_rdata;
  logic              w_s_enb;
  logic              w_s_we;
  logic [ADDR_W-1:0] w_s_addr;
  logic [DATA_W-1:0] w_s_wdata;

  udm_arb_rr_pick u_pick (
    .i_req         ({m1_enb_i, m0_enb_i}),
    .i_last        (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  assign w_busy     = (r_state == ARB_BUSY);
  assign w_complete = w_busy && (s_ack_i || w_force);

  // Next-state logic: leave IDLE on any request, leave BUSY on completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant_valid) w_state_nxt = ARB_BUSY;
        else               w_state_nxt = ARB_IDLE;
      end
      ARB_BUSY: begin
        if (s_ack_i || w_force) w_state_nxt = ARB_IDLE;
        else                    w_state_nxt = ARB_BUSY;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // State, owner and round-robin history registers; M0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= ARB_IDLE;
      r_owner      <= UDM_ARB_M0;
      r_last_grant <= UDM_ARB_M1;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ARB_IDLE) && w_grant_valid) begin
        r_owner      <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
    end
  end

`ifdef UDM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // Watchdog counter and sticky timeout flag; a real ack in the limit cycle wins.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == ARB_IDLE) && w_grant_valid) r_cnt <= '0;
      else if (w_busy)                            r_cnt <= r_cnt + CNT_W'(1);
      if (w_force) r_timeout <= 1'b1;
    end
  end

  assign w_force   = w_busy && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !s_ack_i;
  assign timeout_o = r_timeout;
`else
  assign w_force   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  assign w_ack_rdata = w_force ? TIMEOUT_RDATA : s_rdata_bi;

  // Slave-side mux: owner's request while BUSY, all zero while IDLE.
  always_comb begin
    w_s_enb   = 1'b0;
    w_s_we    = 1'b0;
    w_s_addr  = '0;
    w_s_wdata = '0;
    if (w_busy) begin
      if (r_owner == UDM_ARB_M1) begin
        w_s_enb   = m1_enb_i;
        w_s_we    = m1_we_i;
        w_s_addr  = m1_addr_bi;
        w_s_wdata = m1_wdata_bi;
      end else begin
        w_s_enb   = m0_enb_i;
        w_s_we    = m0_we_i;
        w_s_addr  = m0_addr_bi;
        w_s_wdata = m0_wdata_bi;
      end
    end else begin
      w_s_enb   = 1'b0;
      w_s_we    = 1'b0;
      w_s_addr  = '0;
      w_s_wdata = '0;
    end
  end

  assign s_enb_o     = w_s_enb;
  assign s_we_o      = w_s_we;
  assign s_addr_bo   = w_s_addr;
  assign s_wdata_bo  = w_s_wdata;

  // Acks pass through in the same cycle as the slave ack, only to the owner.
  assign m0_ack_o    = w_complete && (r_owner == UDM_ARB_M0);
  assign m1_ack_o    = w_complete && (r_owner == UDM_ARB_M1);
  assign m0_rdata_bo = m0_ack_o ? w_ack_rdata : '0;
  assign m1_rdata_bo = m1_ack_o ? w_ack_rdata : '0;

  assign owner_o     = r_owner;
  assign busy_o      = w_busy;

endmodule

// File: tb/tb_udm_bus_arbiter.sv
// Self-checking bench for udm_bus_arbiter; timeout scenarios run only when
// UDM_ARB_TIMEOUT_EN is defined.
module tb_udm_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_enb_i, m0_we_i, m1_enb_i, m1_we_i;
  logic [31:0] m0_addr_bi, m0_wdata_bi, m1_addr_bi, m1_wdata_bi;
  logic        m0_ack_o, m1_ack_o;
  logic [31:0] m0_rdata_bo, m1_rdata_bo;
  logic        s_enb_o, s_we_o, s_ack_i;
  logic [31:0] s_addr_bo, s_wdata_bo, s_rdata_bi;
  logic        owner_o, busy_o, timeout_o;

  typedef struct packed {
    logic        idx;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  udm_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16), .TIMEOUT_RDATA(32'hDEADBEEF)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_enb_i(m0_enb_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi), .m0_wdata_bi(m0_wdata_bi),
    .m0_ack_o(m0_ack_o), .m0_rdata_bo(m0_rdata_bo),
    .m1_enb_i(m1_enb_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi), .m1_wdata_bi(m1_wdata_bi),
    .m1_ack_o(m1_ack_o), .m1_rdata_bo(m1_rdata_bo),
    .s_enb_o(s_enb_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo), .s_wdata_bo(s_wdata_bo),
    .s_ack_i(s_ack_i), .s_rdata_bi(s_rdata_bi),
    .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  task automatic idle_inputs();
    m0_enb_i = 1'b0; m0_we_i = 1'b0; m0_addr_bi = 32'h0; m0_wdata_bi = 32'h0;
    m1_enb_i = 1'b0; m1_we_i = 1'b0; m1_addr_bi = 32'h0; m1_wdata_bi = 32'h0;
    s_ack_i = 1'b0; s_rdata_bi = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy_o, s_enb_o, s_we_o, owner_o, m0_ack_o, m1_ack_o, timeout_o} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {busy_o, s_enb_o, s_we_o, owner_o, m0_ack_o, m1_ack_o, timeout_o});
    end
    n_cmp++;
    if ({s_addr_bo, s_wdata_bo, m0_rdata_bo, m1_rdata_bo} !== 128'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h %h %h %h expected all 0",
               s_addr_bo, s_wdata_bo, m0_rdata_bo, m1_rdata_bo);
    end
    rst_i = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    m0_enb_i = 1'b1; m0_we_i = 1'b0; m0_addr_bi = 32'h10; s_rdata_bi = 32'hFFFF_FFFF;
    e.idx = 1'b0; e.rdata = 32'h12345678; sb.push_back(e);
    #1;
    n_cmp++;
    if (s_enb_o !== 1'b0) begin
      n_err++; $display("FAIL rd_req_cycle: s_enb_o got %b expected 0", s_enb_o);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({s_enb_o, busy_o, owner_o, s_we_o} !== 4'b1100 || s_addr_bo !== 32'h10) begin
      n_err++;
      $display("FAIL rd_grant: enb/busy/owner/we got %b addr %h expected 1100 addr 00000010",
               {s_enb_o, busy_o, owner_o, s_we_o}, s_addr_bo);
    end
    repeat (2) begin
      @(negedge clk); #1;
      n_cmp++;
      if (m0_ack_o !== 1'b0 || m0_rdata_bo !== 32'h0 || busy_o !== 1'b1) begin
        n_err++;
        $display("FAIL rd_wait: ack %b rdata %h busy %b expected 0 00000000 1",
                 m0_ack_o, m0_rdata_bo, busy_o);
      end
    end
    @(negedge clk);
    s_ack_i = 1'b1; s_rdata_bi = 32'h12345678;
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (m0_ack_o !== 1'b1 || m0_rdata_bo !== e.rdata) begin
      n_err++;
      $display("FAIL rd_ack: m0_ack %b rdata %h expected 1 %h", m0_ack_o, m0_rdata_bo, e.rdata);
    end
    n_cmp++;
    if (m1_ack_o !== 1'b0 || m1_rdata_bo !== 32'h0) begin
      n_err++;
      $display("FAIL rd_nonowner: m1_ack %b rdata %h expected 0 00000000", m1_ack_o, m1_rdata_bo);
    end
    @(negedge clk);
    s_ack_i = 1'b0; s_rdata_bi = 32'h0; m0_enb_i = 1'b0;
    #1;
    n_cmp++;
    if (s_enb_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL rd_release: s_enb %b busy %b expected 0 0", s_enb_o, busy_o);
    end
  endtask

  task automatic test_tie_alternate();
    bit ok;
    do_reset();
    @(negedge clk);
    m0_enb_i = 1'b1; m0_addr_bi = 32'h100;
    m1_enb_i = 1'b1; m1_addr_bi = 32'h104;
    for (int i = 0; i < 4; i++) begin
      e.idx = 1'(i % 2); e.rdata = 32'hA000_0000 + 32'(i); sb.push_back(e);
      ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk); #1;
        if (busy_o === 1'b1) begin ok = 1'b1; break; end
      end
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL tie_busy_%0d: busy_o got 0 expected 1 within 8 cycles", i);
      end
      n_cmp++;
      if (owner_o !== sb[0].idx || s_addr_bo !== (sb[0].idx ? 32'h104 : 32'h100)) begin
        n_err++;
        $display("FAIL tie_owner_%0d: owner %b addr %h expected owner %b", i, owner_o, s_addr_bo, sb[0].idx);
      end
      s_ack_i = 1'b1; s_rdata_bi = sb[0].rdata;
      #1;
      e = sb.pop_front();
      n_cmp++;
      if ({m1_ack_o, m0_ack_o} !== (e.idx ? 2'b10 : 2'b01) ||
          (e.idx ? m1_rdata_bo : m0_rdata_bo) !== e.rdata) begin
        n_err++;
        $display("FAIL tie_ack_%0d: acks %b%b rdata %h/%h expected master %b data %h",
                 i, m1_ack_o, m0_ack_o, m1_rdata_bo, m0_rdata_bo, e.idx, e.rdata);
      end
      @(negedge clk);
      s_ack_i = 1'b0; s_rdata_bi = 32'h0;
      #1;
      n_cmp++;
      if (busy_o !== 1'b0) begin
        n_err++; $display("FAIL tie_gap_%0d: busy_o got 1 expected 0", i);
      end
    end
    m0_enb_i = 1'b0; m1_enb_i = 1'b0;
  endtask

  task automatic test_write_m1();
    do_reset();
    @(negedge clk);
    m0_addr_bi = 32'hFFF0; m0_wdata_bi = 32'h1111_1111;
    m1_enb_i = 1'b1; m1_we_i = 1'b1; m1_addr_bi = 32'h200; m1_wdata_bi = 32'hCAFEF00D;
    e.idx = 1'b1; e.rdata = 32'h0000_0042; sb.push_back(e);
    repeat (2) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({busy_o, owner_o, s_enb_o, s_we_o} !== 4'b1111 || s_addr_bo !== 32'h200 ||
          s_wdata_bo !== 32'hCAFEF00D) begin
        n_err++;
        $display("FAIL wr_bus: busy/owner/enb/we %b addr %h wdata %h expected 1111 00000200 cafef00d",
                 {busy_o, owner_o, s_enb_o, s_we_o}, s_addr_bo, s_wdata_bo);
      end
    end
    s_ack_i = 1'b1; s_rdata_bi = 32'h0000_0042;
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || m1_rdata_bo !== e.rdata) begin
      n_err++;
      $display("FAIL wr_ack: m1_ack %b m0_ack %b rdata %h expected 1 0 %h",
               m1_ack_o, m0_ack_o, m1_rdata_bo, e.rdata);
    end
    @(negedge clk);
    s_ack_i = 1'b0; m1_enb_i = 1'b0;
    #1;
    n_cmp++;
    if ({s_enb_o, s_we_o} !== 2'b00 || s_addr_bo !== 32'h0 || s_wdata_bo !== 32'h0) begin
      n_err++;
      $display("FAIL wr_idle_bus: enb/we %b addr %h wdata %h expected 00 0 0",
               {s_enb_o, s_we_o}, s_addr_bo, s_wdata_bo);
    end
    m1_we_i = 1'b0; m1_addr_bi = 32'h0; m1_wdata_bi = 32'h0;
  endtask

  task automatic test_spurious_ack();
    @(negedge clk);
    s_ack_i = 1'b1; s_rdata_bi = 32'h5A5A5A5A;
    #1;
    n_cmp++;
    if ({m0_ack_o, m1_ack_o, busy_o} !== 3'b000 || m0_rdata_bo !== 32'h0 || m1_rdata_bo !== 32'h0) begin
      n_err++;
      $display("FAIL spur_ack: acks/busy %b rdata %h/%h expected 000 0 0",
               {m0_ack_o, m1_ack_o, busy_o}, m0_rdata_bo, m1_rdata_bo);
    end
    @(negedge clk);
    s_ack_i = 1'b0; s_rdata_bi = 32'h0;
    #1;
    n_cmp++;
    if (busy_o !== 1'b0 || s_enb_o !== 1'b0) begin
      n_err++; $display("FAIL spur_state: busy %b s_enb %b expected 0 0", busy_o, s_enb_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    m1_enb_i = 1'b1; m1_addr_bi = 32'h300;
    @(negedge clk); #1;
    n_cmp++;
    if (busy_o !== 1'b1 || owner_o !== 1'b1) begin
      n_err++; $display("FAIL rm_grant: busy %b owner %b expected 1 1", busy_o, owner_o);
    end
    @(negedge clk);
    rst_i = 1'b0; m1_enb_i = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({busy_o, s_enb_o, owner_o, m0_ack_o, m1_ack_o} !== 5'b0 || s_addr_bo !== 32'h0) begin
      n_err++;
      $display("FAIL rm_abort: busy/enb/owner/acks %b addr %h expected 00000 0",
               {busy_o, s_enb_o, owner_o, m0_ack_o, m1_ack_o}, s_addr_bo);
    end
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    s_ack_i = 1'b1; s_rdata_bi = 32'h77;
    #1;
    n_cmp++;
    if ({m0_ack_o, m1_ack_o, busy_o} !== 3'b000) begin
      n_err++; $display("FAIL rm_late_ack: acks/busy %b expected 000", {m0_ack_o, m1_ack_o, busy_o});
    end
    @(negedge clk);
    s_ack_i = 1'b0; s_rdata_bi = 32'h0;
    m0_enb_i = 1'b1; m0_addr_bi = 32'h400;
    m1_enb_i = 1'b1; m1_addr_bi = 32'h404;
    e.idx = 1'b0; e.rdata = 32'h0000_0004; sb.push_back(e);
    @(negedge clk); #1;
    n_cmp++;
    if (busy_o !== 1'b1 || owner_o !== sb[0].idx || s_addr_bo !== 32'h400) begin
      n_err++;
      $display("FAIL rm_tie: busy %b owner %b addr %h expected 1 0 00000400", busy_o, owner_o, s_addr_bo);
    end
    s_ack_i = 1'b1; s_rdata_bi = 32'h0000_0004;
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || m0_rdata_bo !== e.rdata) begin
      n_err++;
      $display("FAIL rm_tie_ack: m0 %b m1 %b rdata %h expected 1 0 %h", m0_ack_o, m1_ack_o, m0_rdata_bo, e.rdata);
    end
    @(negedge clk);
    s_ack_i = 1'b0; s_rdata_bi = 32'h0; m0_enb_i = 1'b0; m1_enb_i = 1'b0;
  endtask

`ifdef UDM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int  cnt;
    bit  got;
    do_reset();
    @(negedge clk);
    m0_enb_i = 1'b1; m0_addr_bi = 32'h20; s_rdata_bi = 32'h1111_1111;
    e.idx = 1'b0; e.rdata = 32'hDEADBEEF; sb.push_back(e);
    cnt = 0; got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (busy_o === 1'b1) cnt++;
      if (m0_ack_o === 1'b1) begin
        got = 1'b1;
        e = sb.pop_front();
        n_cmp++;
        if (cnt != 16 || m0_rdata_bo !== e.rdata) begin
          n_err++;
          $display("FAIL to_force: busy cycles %0d rdata %h expected 16 %h", cnt, m0_rdata_bo, e.rdata);
        end
        break;
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL to_no_ack: m0_ack_o got 0 expected 1 within 40 cycles");
    end
    @(negedge clk);
    m0_enb_i = 1'b0; s_rdata_bi = 32'h0;
    #1;
    n_cmp++;
    if (timeout_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL to_flag: timeout %b busy %b expected 1 0", timeout_o, busy_o);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (timeout_o !== 1'b1) begin
      n_err++; $display("FAIL to_sticky: timeout_o got %b expected 1", timeout_o);
    end
  endtask

  task automatic test_timeout_edge_ack();
    do_reset();
    #1;
    n_cmp++;
    if (timeout_o !== 1'b0) begin
      n_err++; $display("FAIL to_rst_clear: timeout_o got %b expected 0", timeout_o);
    end
    @(negedge clk);
    m0_enb_i = 1'b1; m0_addr_bi = 32'h24;
    e.idx = 1'b0; e.rdata = 32'h5555AAAA; sb.push_back(e);
    repeat (15) @(negedge clk);
    @(negedge clk);
    s_ack_i = 1'b1; s_rdata_bi = 32'h5555AAAA;
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (m0_ack_o !== 1'b1 || m0_rdata_bo !== e.rdata) begin
      n_err++;
      $display("FAIL to_edge_ack: ack %b rdata %h expected 1 %h", m0_ack_o, m0_rdata_bo, e.rdata);
    end
    @(negedge clk);
    s_ack_i = 1'b0; s_rdata_bi = 32'h0; m0_enb_i = 1'b0;
    #1;
    n_cmp++;
    if (timeout_o !== 1'b0 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL to_edge_flag: timeout %b busy %b expected 0 0", timeout_o, busy_o);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_tie_alternate();
    test_write_m1();
    test_spurious_ack();
    test_reset_mid();
`ifdef UDM_ARB_TIMEOUT_EN
    test_timeout();
    test_timeout_edge_ack();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
